// File: rtl/input_port_buffer_if.sv
// Router input-port bundle: upstream flit handshake, route-computation loop,
// switch-arbiter request/grant, and the departing-flit bus.
interface input_port_buffer_if #(
    parameter int unsigned address_length = 16,
    parameter int unsigned data_length    = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [address_length-1:0] in_address;
    logic [data_length-1:0]    in_data;
    logic [address_length-1:0] head_address;
    logic [address_length-1:0] next_address;
    logic [4:0]                request_vector;
    logic [4:0]                req;
    logic [4:0]                grant;
    logic                      out_valid;
    logic [address_length-1:0] out_address;
    logic [data_length-1:0]    out_data;

    // Environment side: upstream router, route computation and arbiters.
    modport master (
        output in_valid, in_address, in_data, next_address, request_vector, grant,
        input  in_ready, head_address, req, out_valid, out_address, out_data
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_address, in_data, next_address, request_vector, grant,
        output in_ready, head_address, req, out_valid, out_address, out_data
    );
endinterface

// File: rtl/input_port_buffer.sv
// Router input stage: buffers flits, latches the XY route decision for the head
// flit, holds the request to the switch arbiters until granted, then emits the flit.
module input_port_buffer #(
    parameter int unsigned address_length   = 16,
    parameter int unsigned x_address_length = 8,
    parameter int unsigned y_address_length = 8,
    parameter int unsigned data_length      = 32,
    parameter int unsigned fifo_depth       = 4,
    parameter int unsigned ptr_width        = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input_port_buffer_if.slave   bus
);
    localparam int unsigned count_width = ptr_width + 1;

    if (fifo_depth != (1 << ptr_width) || fifo_depth < 2) begin : g_bad_depth
        $error("fifo_depth must be a power of two >= 2 equal to 2**ptr_width");
    end
    if (x_address_length + y_address_length != address_length) begin : g_bad_addr
        $error("x/y address widths must sum to address_length");
    end

    typedef struct packed {
        logic [data_length-1:0]    data;
        logic [address_length-1:0] address;
    } flit_t;

    typedef enum logic {
        st_idle,
        st_wait
    } state_t;

    flit_t                     mem [fifo_depth];
    logic [ptr_width-1:0]      rd_ptr;
    logic [ptr_width-1:0]      wr_ptr;
    logic [count_width-1:0]    count;
    logic [4:0]                req_q;
    logic [address_length-1:0] nxt_q;
    state_t                    state;
    state_t                    state_next;

    logic full_c;
    logic empty_c;
    logic push_c;
    logic latch_c;
    logic pop_c;

    assign full_c           = (count == count_width'(fifo_depth));
    assign empty_c          = (count == '0);
    assign push_c           = bus.in_valid && !full_c;
    assign bus.in_ready     = !full_c;
    assign bus.head_address = mem[rd_ptr].address;
    assign bus.req          = req_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= st_idle;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            st_idle: if (!empty_c) state_next = st_wait;
            st_wait: if (|(bus.grant & req_q)) state_next = st_idle;
            default: state_next = st_idle;
        endcase
    end

    // FSM controls: latch the route in IDLE, pop on a grant matching the held request.
    always_comb begin
        latch_c = 1'b0;
        pop_c   = 1'b0;
        case (state)
            st_idle: latch_c = !empty_c;
            st_wait: pop_c   = |(bus.grant & req_q);
            default: ;
        endcase
    end

    // Flit storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{data: bus.in_data, address: bus.in_address};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + ptr_width'(1);
            if (pop_c)  rd_ptr <= rd_ptr + ptr_width'(1);
            case ({push_c, pop_c})
                2'b10:   count <= count + count_width'(1);
                2'b01:   count <= count - count_width'(1);
                default: count <= count;
            endcase
        end
    end

    // req_q is zero whenever the FSM is idle, so it drives the arbiters directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            nxt_q <= '0;
        end else if (latch_c) begin
            req_q <= bus.request_vector;
            nxt_q <= bus.next_address;
        end else if (pop_c) begin
            req_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid   <= 1'b0;
            bus.out_address <= '0;
            bus.out_data    <= '0;
        end else begin
            bus.out_valid <= pop_c;
            if (pop_c) begin
                bus.out_address <= nxt_q;
                bus.out_data    <= mem[rd_ptr].data;
            end
        end
    end
endmodule
